// File: rtl/layer_sequencer_pkg.sv
// Shared types and default widths for the layer sequencer slice.
package gusn_pkg;

  localparam int unsigned NUM_W_DEF      = 16;
  localparam int unsigned RAM_ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETTLE,
    WAIT,
    NEXT
  } seq_state_t;

  typedef enum logic {
    DIR_F,
    DIR_B
  } dir_t;

endpackage

// File: rtl/layer_sequencer_shared_port_mux.sv
// One-of-N bus selector; output forced to zero when not enabled.
module shared_port_mux #(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = 1
) (
  input  logic [N-1:0][W-1:0] i_data,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_en,
  output logic [W-1:0]        o_data
);

  always_comb begin
    o_data = '0;
    if (i_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i_sel == SEL_W'(i)) o_data = i_data[i];
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Forward/backward start sequencer for a layer stack sharing one RAM and one multiplier.
// Optional GUSN_PERF_CNT_EN adds a saturating busy-cycle counter output cyc_cnt.
module layer_sequencer
  import gusn_pkg::*;
#(
  parameter int unsigned LAYERS     = 2,
  parameter int unsigned NUM_W      = NUM_W_DEF,
  parameter int unsigned RAM_ADDR_W = RAM_ADDR_W_DEF,
  parameter int unsigned IDX_W      = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                                clk,
  input  logic                                nreset,
  input  logic                                enable,
  input  logic                                run_f,
  input  logic                                run_b,
  output logic                                busy,
  output logic                                done,
  output logic [IDX_W-1:0]                    active_idx,
  output logic [LAYERS-1:0]                   layer_start_f,
  output logic [LAYERS-1:0]                   layer_start_b,
  input  logic [LAYERS-1:0]                   layer_ready,
  input  logic [LAYERS-1:0]                   l_ram_write,
  input  logic [LAYERS-1:0][RAM_ADDR_W-1:0]   l_ram_addr_write,
  input  logic [LAYERS-1:0][NUM_W-1:0]        l_ram_data_write,
  input  logic [LAYERS-1:0][RAM_ADDR_W-1:0]   l_ram_addr_read,
  input  logic [LAYERS-1:0][NUM_W-1:0]        l_mult_v1,
  input  logic [LAYERS-1:0][NUM_W-1:0]        l_mult_v2,
  output logic                                ram_write,
  output logic [RAM_ADDR_W-1:0]               ram_addr_write,
  output logic [RAM_ADDR_W-1:0]               ram_addr_read,
  output logic [NUM_W-1:0]                    ram_data_write,
  output logic [NUM_W-1:0]                    mult_v1,
  output logic [NUM_W-1:0]                    mult_v2
`ifdef GUSN_PERF_CNT_EN
  ,
  output logic [31:0]                         cyc_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYERS - 1);
  localparam int unsigned RAM_W  = 1 + 2 * RAM_ADDR_W + NUM_W;
  localparam int unsigned MULT_W = 2 * NUM_W;

  seq_state_t       r_state, w_state_nxt;
  dir_t             r_dir, w_dir_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_pend_f, w_pend_f_nxt;
  logic             r_pend_b, w_pend_b_nxt;
  logic             w_ready_sel;
  logic             w_last;
  logic             w_first;
  logic             w_final;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_first = (r_idx == '0);
  // Final layer of the last pending direction: sequence ends after this NEXT.
  assign w_final = ((r_dir == DIR_F) && w_last && !r_pend_b) || ((r_dir == DIR_B) && w_first);

  always_comb begin
    w_ready_sel = 1'b0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (r_idx == IDX_W'(i)) w_ready_sel = layer_ready[i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= IDLE;
      r_dir    <= DIR_F;
      r_idx    <= '0;
      r_pend_f <= 1'b0;
      r_pend_b <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_idx    <= w_idx_nxt;
      r_pend_f <= w_pend_f_nxt;
      r_pend_b <= w_pend_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_idx_nxt    = r_idx;
    w_pend_f_nxt = r_pend_f;
    w_pend_b_nxt = r_pend_b;
    if (enable) begin
      unique case (r_state)
        IDLE: begin
          if (run_f || run_b) begin
            w_pend_f_nxt = run_f;
            w_pend_b_nxt = run_b;
            w_state_nxt  = START;
            if (run_f) begin
              w_dir_nxt = DIR_F;
              w_idx_nxt = '0;
            end else begin
              w_dir_nxt = DIR_B;
              w_idx_nxt = LAST_IDX;
            end
          end
        end
        START:  w_state_nxt = SETTLE;
        SETTLE: w_state_nxt = WAIT;
        WAIT:   if (w_ready_sel) w_state_nxt = NEXT;
        NEXT: begin
          w_state_nxt = START;
          if ((r_dir == DIR_F) && !w_last) begin
            w_idx_nxt = r_idx + 1'b1;
          end else if ((r_dir == DIR_B) && !w_first) begin
            w_idx_nxt = r_idx - 1'b1;
          end else if ((r_dir == DIR_F) && r_pend_b) begin
            w_pend_f_nxt = 1'b0;
            w_dir_nxt    = DIR_B;
            w_idx_nxt    = LAST_IDX;
          end else begin
            w_pend_f_nxt = 1'b0;
            w_pend_b_nxt = 1'b0;
            w_dir_nxt    = DIR_F;
            w_idx_nxt    = '0;
            w_state_nxt  = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    layer_start_f = '0;
    layer_start_b = '0;
    done          = (r_state == NEXT) && enable && w_final;
    busy          = (r_state != IDLE);
    active_idx    = r_idx;
    if ((r_state == START) && enable) begin
      for (int unsigned i = 0; i < LAYERS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          if (r_dir == DIR_F) layer_start_f[i] = 1'b1;
          else                layer_start_b[i] = 1'b1;
        end
      end
    end
  end

  logic [LAYERS-1:0][RAM_W-1:0]  w_ram_bus;
  logic [LAYERS-1:0][MULT_W-1:0] w_mult_bus;
  logic [RAM_W-1:0]              w_ram_sel;
  logic [MULT_W-1:0]             w_mult_sel;

  always_comb begin
    for (int unsigned i = 0; i < LAYERS; i++) begin
      w_ram_bus[i]  = {l_ram_write[i], l_ram_addr_write[i], l_ram_data_write[i], l_ram_addr_read[i]};
      w_mult_bus[i] = {l_mult_v1[i], l_mult_v2[i]};
    end
  end

  shared_port_mux #(.N(LAYERS), .W(RAM_W), .SEL_W(IDX_W)) u_ram_mux (
    .i_data (w_ram_bus),
    .i_sel  (r_idx),
    .i_en   (busy),
    .o_data (w_ram_sel)
  );

  shared_port_mux #(.N(LAYERS), .W(MULT_W), .SEL_W(IDX_W)) u_mult_mux (
    .i_data (w_mult_bus),
    .i_sel  (r_idx),
    .i_en   (busy),
    .o_data (w_mult_sel)
  );

  assign {ram_write, ram_addr_write, ram_data_write, ram_addr_read} = w_ram_sel;
  assign {mult_v1, mult_v2} = w_mult_sel;

`ifdef GUSN_PERF_CNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cyc_cnt <= '0;
    end else if ((r_state == IDLE) && (w_state_nxt != IDLE)) begin
      r_cyc_cnt <= '0;
    end else if (busy && enable && (r_cyc_cnt != '1)) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer with 3-layer and 2-layer instances.
module tb_layer_sequencer;

  localparam int NW = 16;
  localparam int AW = 8;

  typedef struct {
    int cyc;
    int dir;
    int idx;
  } ev_t;

  typedef struct {
    bit rf;
    bit rb;
    int d;
    int off3;
    int off2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset, enable, run_f, run_b;
  logic [2:0]         ready3 = '1;
  logic [1:0]         ready2 = '1;
  logic [2:0]         l_ram_write;
  logic [2:0][AW-1:0] l_ram_addr_write, l_ram_addr_read;
  logic [2:0][NW-1:0] l_ram_data_write, l_mult_v1, l_mult_v2;

  logic          busy3, done3, ram_write3;
  logic [1:0]    idx3;
  logic [2:0]    sf3, sb3;
  logic [AW-1:0] raw3, rar3;
  logic [NW-1:0] rdw3, mv1_3, mv2_3;

  logic          busy2, done2, ram_write2;
  logic [0:0]    idx2;
  logic [1:0]    sf2, sb2;
  logic [AW-1:0] raw2, rar2;
  logic [NW-1:0] rdw2, mv1_2, mv2_2;

  layer_sequencer #(.LAYERS(3), .NUM_W(NW), .RAM_ADDR_W(AW)) dut3 (
    .clk(clk), .nreset(nreset), .enable(enable), .run_f(run_f), .run_b(run_b),
    .busy(busy3), .done(done3), .active_idx(idx3),
    .layer_start_f(sf3), .layer_start_b(sb3), .layer_ready(ready3),
    .l_ram_write(l_ram_write), .l_ram_addr_write(l_ram_addr_write),
    .l_ram_data_write(l_ram_data_write), .l_ram_addr_read(l_ram_addr_read),
    .l_mult_v1(l_mult_v1), .l_mult_v2(l_mult_v2),
    .ram_write(ram_write3), .ram_addr_write(raw3), .ram_addr_read(rar3),
    .ram_data_write(rdw3), .mult_v1(mv1_3), .mult_v2(mv2_3)
  );

  layer_sequencer #(.LAYERS(2), .NUM_W(NW), .RAM_ADDR_W(AW)) dut2 (
    .clk(clk), .nreset(nreset), .enable(enable), .run_f(run_f), .run_b(run_b),
    .busy(busy2), .done(done2), .active_idx(idx2),
    .layer_start_f(sf2), .layer_start_b(sb2), .layer_ready(ready2),
    .l_ram_write(l_ram_write[1:0]), .l_ram_addr_write(l_ram_addr_write[1:0]),
    .l_ram_data_write(l_ram_data_write[1:0]), .l_ram_addr_read(l_ram_addr_read[1:0]),
    .l_mult_v1(l_mult_v1[1:0]), .l_mult_v2(l_mult_v2[1:0]),
    .ram_write(ram_write2), .ram_addr_write(raw2), .ram_addr_read(rar2),
    .ram_data_write(rdw2), .mult_v1(mv1_2), .mult_v2(mv2_2)
  );

  // Layer model: ready drops when started and returns dly cycles later.
  int dly = 3;
  int cnt3[3] = '{default: 0};
  int cnt2[2] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sf3[i] || sb3[i]) begin
        cnt3[i] <= dly; ready3[i] <= 1'b0;
      end else if (cnt3[i] == 1) begin
        cnt3[i] <= 0; ready3[i] <= 1'b1;
      end else if (cnt3[i] > 1) cnt3[i] <= cnt3[i] - 1;
    end
    for (int j = 0; j < 2; j++) begin
      if (sf2[j] || sb2[j]) begin
        cnt2[j] <= dly; ready2[j] <= 1'b0;
      end else if (cnt2[j] == 1) begin
        cnt2[j] <= 0; ready2[j] <= 1'b1;
      end else if (cnt2[j] > 1) cnt2[j] <= cnt2[j] - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t ev3[$];
  ev_t ev2[$];
  int  done3_n, done2_n, done3_cyc, done2_cyc;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sf3[i]) ev3.push_back('{cyc, 0, i});
      if (sb3[i]) ev3.push_back('{cyc, 1, i});
    end
    for (int j = 0; j < 2; j++) begin
      if (sf2[j]) ev2.push_back('{cyc, 0, j});
      if (sb2[j]) ev2.push_back('{cyc, 1, j});
    end
    if (done3) begin done3_n++; done3_cyc = cyc; end
    if (done2) begin done2_n++; done2_cyc = cyc; end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ev3.delete();
    ev2.delete();
    done3_n = 0;
    done2_n = 0;
    done3_cyc = -1;
    done2_cyc = -1;
  endtask

  task automatic launch(input bit rf, input bit rb, output int t0);
    run_f = rf;
    run_b = rb;
    t0 = cyc;
    step();
    run_f = 1'b0;
    run_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy3 || busy2) && n < 3000) begin
      step();
      n++;
    end
    check("idle_reached", (n < 3000), 1);
  endtask

  // Reference: starts in network order, one every d+3 cycles, done d+2 after the last.
  task automatic verify(input string tag, input int L, input bit rf, input bit rb, input int d,
                        input int t0, input ev_t log[$], input int dn, input int dcyc);
    ev_t exp[$];
    int  t = t0 + 1;
    if (rf) for (int i = 0; i < L; i++) begin exp.push_back('{t, 0, i}); t += d + 3; end
    if (rb) for (int i = L - 1; i >= 0; i--) begin exp.push_back('{t, 1, i}); t += d + 3; end
    check({tag, "_nstarts"}, log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < log.size(); k++) begin
      check($sformatf("%s_ev%0d_cyc", tag, k), log[k].cyc, exp[k].cyc);
      check($sformatf("%s_ev%0d_dir", tag, k), log[k].dir, exp[k].dir);
      check($sformatf("%s_ev%0d_idx", tag, k), log[k].idx, exp[k].idx);
    end
    check({tag, "_done_n"}, dn, 1);
    check({tag, "_done_cyc"}, dcyc, t - 1);
  endtask

  task automatic run_and_check(input string tag, input bit rf, input bit rb, input int d,
                               output int off3, output int off2);
    int t0;
    dly = d;
    clear_log();
    launch(rf, rb, t0);
    wait_idle();
    verify({tag, "_L3"}, 3, rf, rb, d, t0, ev3, done3_n, done3_cyc);
    verify({tag, "_L2"}, 2, rf, rb, d, t0, ev2, done2_n, done2_cyc);
    check({tag, "_busy3_after"}, busy3, 0);
    check({tag, "_busy2_after"}, busy2, 0);
    off3 = done3_cyc - (t0 + 1);
    off2 = done2_cyc - (t0 + 1);
  endtask

  vec_t tbl[4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, o3, o2, n, nb, nf0;
    bit rf, rb;

    tbl[0] = '{1'b1, 1'b0, 5, 23, 15};
    tbl[1] = '{1'b1, 1'b1, 5, 47, 31};
    tbl[2] = '{1'b0, 1'b1, 1, 11, 7};
    tbl[3] = '{1'b1, 1'b1, 2, 29, 19};

    nreset = 1'b0; enable = 1'b1; run_f = 1'b0; run_b = 1'b0;
    l_ram_write = '1;
    for (int i = 0; i < 3; i++) begin
      l_ram_addr_write[i] = AW'(8'h10 + i);
      l_ram_addr_read[i]  = AW'(8'h40 + i);
      l_ram_data_write[i] = NW'(16'h1111 * (i + 1));
      l_mult_v1[i]        = NW'(16'h0101 * (i + 1));
      l_mult_v2[i]        = NW'(16'h1010 * (i + 1));
    end
    step(); step();
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_idx", idx3, 0);
    check("rst_sf", sf3, 0);
    check("rst_sb", sb3, 0);
    check("rst_ram_write", ram_write3, 0);
    check("rst_ram_addr", raw3, 0);
    check("rst_mult_v1", mv1_3, 0);
    nreset = 1'b1;
    l_ram_write = '0;
    step();

    for (int v = 0; v < 4; v++) begin
      run_and_check($sformatf("tbl%0d", v), tbl[v].rf, tbl[v].rb, tbl[v].d, o3, o2);
      check($sformatf("tbl%0d_off3", v), o3, tbl[v].off3);
      check($sformatf("tbl%0d_off2", v), o2, tbl[v].off2);
      step();
    end

    for (int r = 0; r < 6; r++) begin
      rf = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!rf && !rb) rf = 1'b1;
      run_and_check($sformatf("rnd%0d", r), rf, rb, int'($urandom_range(1, 7)), o3, o2);
      repeat ($urandom_range(0, 3)) step();
    end

    // Grant mux: idle force-zero, then only the active layer reaches the shared ports.
    l_ram_write = '1;
    step();
    check("idle_ram_write", ram_write3, 0);
    check("idle_ram_addr", raw3, 0);
    check("idle_mult_v1", mv1_3, 0);
    l_ram_write = 3'b010;
    dly = 12;
    clear_log();
    launch(1'b1, 1'b0, t0);
    step(); step(); step();
    check("g0_idx", idx3, 0);
    check("g0_ram_write", ram_write3, 0);
    check("g0_addr_w", raw3, 8'h10);
    check("g0_data_w", rdw3, 16'h1111);
    check("g0_addr_r", rar3, 8'h40);
    check("g0_mult_v2", mv2_3, 16'h1010);
    l_ram_write = 3'b011;
    #1;
    check("g0_ram_write_on", ram_write3, 1);
    n = 0;
    while (idx3 != 2'd1 && n < 100) begin step(); n++; end
    check("g1_reached", (n < 100), 1);
    check("g1_ram_write", ram_write3, 1);
    check("g1_addr_w", raw3, 8'h11);
    check("g1_data_w", rdw3, 16'h2222);
    check("g1_mult_v1", mv1_3, 16'h0202);
    wait_idle();
    l_ram_write = '1;
    step();
    check("idle2_ram_write", ram_write3, 0);
    l_ram_write = '0;

    // Enable dropped for four cycles while in START.
    dly = 2;
    clear_log();
    run_f = 1'b1;
    t0 = cyc;
    step();
    run_f = 1'b0;
    enable = 1'b0;
    repeat (4) step();
    enable = 1'b1;
    wait_idle();
    check("en_nstarts", ev3.size(), 3);
    if (ev3.size() > 0) begin
      check("en_first_cyc", ev3[0].cyc, t0 + 5);
      check("en_first_idx", ev3[0].idx, 0);
    end
    nf0 = 0;
    foreach (ev3[k]) if (ev3[k].idx == 0 && ev3[k].dir == 0) nf0++;
    check("en_f0_pulses", nf0, 1);
    check("en_done_n", done3_n, 1);

    // Requests while busy are dropped, not queued.
    dly = 3;
    clear_log();
    launch(1'b1, 1'b0, t0);
    repeat (4) begin
      step();
      run_f = 1'b1; run_b = 1'b1;
      step();
      run_f = 1'b0; run_b = 1'b0;
    end
    wait_idle();
    step(); step(); step();
    nb = 0;
    foreach (ev3[k]) if (ev3[k].dir == 1) nb++;
    check("ign_nstarts", ev3.size(), 3);
    check("ign_nback", nb, 0);
    check("ign_done_n", done3_n, 1);
    check("ign_busy_after", busy3, 0);

    // Asynchronous reset in WAIT of layer 1, then a fresh run from layer 0.
    dly = 10;
    clear_log();
    launch(1'b1, 1'b0, t0);
    n = 0;
    while (ev3.size() < 2 && n < 200) begin step(); n++; end
    check("rst_mid_reached", (n < 200), 1);
    step(); step(); step();
    check("rst_mid_pre_idx", idx3, 1);
    check("rst_mid_pre_busy", busy3, 1);
    l_ram_write = '1;
    #2 nreset = 1'b0;
    #1;
    check("rst_mid_busy", busy3, 0);
    check("rst_mid_idx", idx3, 0);
    check("rst_mid_sf", sf3, 0);
    check("rst_mid_sb", sb3, 0);
    check("rst_mid_done", done3, 0);
    check("rst_mid_ram_write", ram_write3, 0);
    step();
    nreset = 1'b1;
    l_ram_write = '0;
    step();
    dly = 2;
    clear_log();
    launch(1'b1, 1'b0, t0);
    wait_idle();
    verify("rst_restart_L3", 3, 1'b1, 1'b0, 2, t0, ev3, done3_n, done3_cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level scheduler for a stack of LAYER instances that share one RAM_WRAPPER and one MULT_WRAPPER.
- Issues start_f/start_b pulses in network order: forward 0..LAYERS-1, backward LAYERS-1..0.
- Waits for each layer's ready handshake before moving on.
- Grants the shared RAM write/read ports and multiplier operands to the active layer only.

Parameters:
- LAYERS, 2, number of sequenced layer instances (>=1).
- NUM_W, 16, fixed-point word width (INT_W+FRAC_W).
- RAM_ADDR_W, 8, shared RAM address width.
- IDX_W, $clog2(LAYERS) (min 1), layer index width.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous, active-low reset
- enable  in  1  global advance enable
- run_f  in  1  request forward pass
- run_b  in  1  request backward pass
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the requested sequence completes
- active_idx  out  IDX_W  index of the granted layer (0 when idle)
- layer_start_f  out  LAYERS  per-layer forward start pulse
- layer_start_b  out  LAYERS  per-layer backward start pulse
- layer_ready  in  LAYERS  per-layer ready_out
- l_ram_write  in  LAYERS  per-layer RAM write strobe
- l_ram_addr_write  in  [LAYERS][RAM_ADDR_W]  per-layer write address
- l_ram_data_write  in  [LAYERS][NUM_W]  per-layer write data
- l_ram_addr_read  in  [LAYERS][RAM_ADDR_W]  per-layer read address
- l_mult_v1, l_mult_v2  in  [LAYERS][NUM_W]  per-layer multiplier operands
- ram_write  out  1  to RAM_WRAPPER
- ram_addr_write, ram_addr_read  out  RAM_ADDR_W  to RAM_WRAPPER
- ram_data_write  out  NUM_W  to RAM_WRAPPER
- mult_v1, mult_v2  out  NUM_W  to MULT_WRAPPER
- ram_data_read and mult_res are broadcast to all layers outside this block and do not pass through it.

Behaviour:
- State machine states: IDLE, START, SETTLE, WAIT, NEXT.
- Reset (asynchronous, any state, including mid-sequence):
  - State goes to IDLE; busy=0, done=0, active_idx=0.
  - All start bits are 0; the sequencer holds no pending-pass flags.
  - All shared outputs are 0 (ram_write=0).
- IDLE:
  - Sampled on a clk edge with enable=1. run_f -> set pend_f; run_b -> set pend_b.
  - If both are set, forward runs first, then backward (training step).
  - If forward is pending: idx=0, dir=F. Else if only backward is pending: idx=LAYERS-1, dir=B. Next state is START and busy=1.
- START:
  - Drives exactly one start bit, layer_start_{dir}[idx]=1, for one enabled cycle, then goes to SETTLE.
  - If enable=0, the start bit is gated to 0 and the state holds; the pulse is issued on the first enabled cycle.
- SETTLE: one cycle in which layer_ready is ignored, to cover the layer's ready-drop latency. Then goes to WAIT.
- WAIT: holds until layer_ready[idx]=1, then goes to NEXT.
- NEXT:
  - dir=F and idx<LAYERS-1: idx++ and go to START.
  - dir=B and idx>0: idx-- and go to START.
  - dir=F, last layer, pend_b set: clear pend_f, dir=B, idx=LAYERS-1, go to START.
  - Otherwise (final layer of the last pending direction): clear the pend flags, done=1 for one cycle, busy=0 on the next cycle, go to IDLE.
- run_f/run_b while busy: ignored. Requests are not queued.
- Grant:
  - active_idx = idx registered. The shared outputs are a combinational mux of the l_* inputs selected by active_idx while busy.
  - While idle the shared outputs are forced to 0, so a stray idle layer write never reaches RAM.
  - Non-granted layers' ram_write is dropped silently.
- enable=0 freezes the FSM and idx in every state; the grant mux stays live.
- LAYERS=1: forward and backward each take one layer; the F->B turnaround still passes through START.
- Latency per layer: 1 (START) + 1 (SETTLE) + ready wait + 1 (NEXT) cycles.

Optional Feature:
- Macro: GUSN_PERF_CNT_EN.
- With the macro: adds a 32-bit output cyc_cnt, cleared when a sequence leaves IDLE. It increments every enabled busy cycle, saturates at 2^32-1, and holds its value after done until the next run.
- Without the macro: the port and counter are absent.

Decomposition:
- Package gusn_pkg:
  - seq_state_t enum (IDLE, START, SETTLE, WAIT, NEXT).
  - dir_t enum (DIR_F, DIR_B).
  - Default NUM_W/RAM_ADDR_W constants.
- Sub-module shared_port_mux: parameterised one-of-LAYERS mux with an idle force-zero. It is reused for the RAM and multiplier buses.

Test Plan:
- LAYERS=2, pulse run_f, each layer ready 5 cycles after its start -> start_f[0] high one cycle, then start_f[1] high exactly 8 cycles later. done pulses once; busy is low afterwards; no start_b occurs.
- run_f and run_b in the same cycle, LAYERS=3 -> start order f0,f1,f2,b2,b1,b0, each a single-cycle pulse, one done.
- Layer 1 asserts l_ram_write=1, addr 0x10, while layer 0 is granted -> ram_write follows layer 0 only. In IDLE with any l_ram_write=1 -> ram_write=0.
- Drop enable for 4 cycles while in START -> no start pulse during the gap; exactly one pulse after enable returns.
- Assert nreset low in WAIT of layer 1 -> busy=0, all start bits 0, active_idx=0 immediately. A fresh run_f restarts at layer 0.
- run_f asserted while busy -> ignored; the total start-pulse count equals LAYERS.
